uart_cmd_parser: RTL
====================

# uart_cmd_parser

Byte-level command parser directly downstream of the UART receiver in the robot control path. Consumes each received byte (`rx_msg`, `rx_complete` pulse), assembles fixed-format ASCII command frames, validates them, and pushes decoded commands into a small FIFO for the path-planning / motor-control logic. Malformed frames, and bytes the receiver has replaced with `?` (0x3F) after a parity failure, are rejected with an error pulse.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `TIMEOUT_CYCLES`, 1024: idle clocks allowed between bytes inside a frame (only with `CMD_TIMEOUT_EN`).
- `clk_3125`  input  1  3.125 MHz system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `rx_msg`  input  8  received byte, MSB-first as produced by the UART receiver; valid when `rx_complete`=1.
- `rx_complete`  input  1  one-cycle strobe per received byte.
- `cmd_rd`  input  1  pop the head command; ignored when `cmd_empty`=1.
- `cmd_op`  output  2  head opcode: 0=`S` start node, 1=`E` end node, 2=`V` velocity, 3=`H` halt.
- `cmd_arg`  output  7  head argument, 0..99 binary.
- `cmd_empty`  output  1  FIFO empty.
- `cmd_full`  output  1  FIFO holds `FIFO_DEPTH` entries.
- `cmd_error`  output  1  one-cycle pulse per rejected frame.
- `cmd_overflow`  output  1  sticky: a valid command was dropped because the FIFO was full; cleared only by `reset`.

## Operation
- Frame: `#`(0x23), opcode char (`S`,`E`,`V`,`H`), tens digit, units digit (`0`..`9`), `\n`(0x0A). Argument = 10*tens + units, computed in 7 bits (max 99, no overflow).
- States: IDLE, OP, D1, D0, TERM. Advance only on cycles with `rx_complete`=1.
- IDLE: `#` -> OP; any other byte discarded silently, no error.
- OP: valid opcode char -> D1 (opcode latched); else error -> IDLE.
- D1 / D0: digit -> next state (digit latched); else error -> IDLE.
- TERM: `\n` -> push {op, arg} into FIFO, -> IDLE; else error -> IDLE.
- `#` received in OP, D1, D0 or TERM: error pulse, frame restarts (-> OP).
- Byte 0x3F in any non-IDLE state: error -> IDLE (covered by the rules above; explicitly required).
- Push while full: entry dropped, `cmd_overflow` set, no `cmd_error`.
- FIFO is first-word fall-through: `cmd_op`/`cmd_arg` show head entry whenever `cmd_empty`=0; both read 0 when empty.
- Push and pop on the same edge: both performed; count unchanged; legal when full (pop frees the slot, push accepted, no overflow). `cmd_rd` when empty ignored; a simultaneous push still occurs.
- Pointers wrap modulo `FIFO_DEPTH`; count is `clog2(FIFO_DEPTH)+1` bits.

## Timing
- Reset values: state IDLE, FIFO empty, `cmd_empty`=1, `cmd_full`=0, `cmd_op`=0, `cmd_arg`=0, `cmd_error`=0, `cmd_overflow`=0, timeout counter 0.
- `reset` asserted mid-frame: partial frame discarded, FIFO flushed, no error pulse, takes priority over all other inputs that cycle.
- Latency: on the edge where `rx_complete`=1 carries `\n` in TERM, the entry is written; `cmd_empty` falls and head outputs are valid in the following cycle (1 cycle after the strobe).
- `cmd_error` is registered: high for exactly the one cycle after the offending strobe edge.
- `cmd_rd` sampled on the rising edge; next entry (or empty) visible the following cycle.
- `rx_complete` strobes arrive no closer than ~297 clocks apart at 115200 baud; parser still accepts back-to-back strobes every cycle.

## Configuration
- `CMD_TIMEOUT_EN` defined: a counter runs while state != IDLE, cleared on every `rx_complete`; reaching `TIMEOUT_CYCLES` pulses `cmd_error` and returns to IDLE. Counter held at 0 in IDLE.
- Not defined: no timeout logic; a partial frame waits indefinitely for its next byte; `TIMEOUT_CYCLES` unused.

## Test plan
- Reset, then bytes `#`,`S`,`1`,`2`,`\n` -> one cycle after last strobe `cmd_empty`=0, `cmd_op`=0, `cmd_arg`=12; `cmd_error` never high.
- Frame `#`,`V`,`?`,... -> `cmd_error` pulses once after the `?` strobe, FIFO stays empty, next valid `#H00\n` yields `cmd_op`=3, `cmd_arg`=0.
- Five valid frames `#E01\n`..`#E05\n` with no reads (depth 4) -> `cmd_full`=1 after fourth, `cmd_overflow`=1 after fifth; pops return args 1,2,3,4 then `cmd_empty`=1.
- FIFO full, `cmd_rd`=1 on the same edge a `\n` completes `#S99\n` -> no overflow, count stays 4, last popped-in entry arg 99 at tail.
- `#`,`E`,`#`,`E`,`0`,`7`,`\n` -> one error pulse at second `#`, then command op=1 arg=7 pushed.
- With `CMD_TIMEOUT_EN`, TIMEOUT_CYCLES=1024: send `#`,`S`, then idle 1024 clocks -> `cmd_error` pulse, state IDLE; subsequent `1`,`2`,`\n` discarded silently, FIFO empty.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// ASCII command-frame parser ("#<op><d><d>\n") feeding a first-word-fall-through command FIFO.
// Optional inter-byte timeout is compiled in with `define CMD_TIMEOUT_EN.
module uart_cmd_parser #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_3125,
    input  logic       reset,
    input  logic [7:0] rx_msg,
    input  logic       rx_complete,
    input  logic       cmd_rd,
    output logic [1:0] cmd_op,
    output logic [6:0] cmd_arg,
    output logic       cmd_empty,
    output logic       cmd_full,
    output logic       cmd_error,
    output logic       cmd_overflow
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_OP, S_D1, S_D0, S_TERM} state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  tens_q, tens_d;
    logic [6:0]  arg_q, arg_d;
    logic        err_q, err_d;
    logic        push_req;
    logic        is_digit, op_ok;
    logic [1:0]  op_val;
    logic        to_hit;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          ovf_q;
    logic          push, pop;

    assign is_digit = (rx_msg >= 8'h30) && (rx_msg <= 8'h39);

    always_comb begin
        op_ok  = 1'b1;
        op_val = 2'd0;
        case (rx_msg)
            8'h53:   op_val = 2'd0;
            8'h45:   op_val = 2'd1;
            8'h56:   op_val = 2'd2;
            8'h48:   op_val = 2'd3;
            default: op_ok  = 1'b0;
        endcase
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Counts idle clocks inside a frame; any strobe restarts the window.
    always_comb begin
        to_hit   = (state_q != S_IDLE) && !rx_complete && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        to_cnt_d = to_cnt_q + 1'b1;
        if (state_q == S_IDLE || rx_complete || to_hit) to_cnt_d = '0;
    end

    always_ff @(posedge clk_3125) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tens_d   = tens_q;
        arg_d    = arg_q;
        err_d    = 1'b0;
        push_req = 1'b0;
        if (rx_complete) begin
            if (state_q == S_IDLE) begin
                if (rx_msg == 8'h23) state_d = S_OP;
            end else if (rx_msg == 8'h23) begin
                err_d   = 1'b1;
                state_d = S_OP;
            end else begin
                // Default is reject; each state clears the error only on its legal byte.
                state_d = S_IDLE;
                err_d   = 1'b1;
                case (state_q)
                    S_OP: if (op_ok) begin
                        op_d = op_val; state_d = S_D1; err_d = 1'b0;
                    end
                    S_D1: if (is_digit) begin
                        tens_d = rx_msg[3:0]; state_d = S_D0; err_d = 1'b0;
                    end
                    S_D0: if (is_digit) begin
                        arg_d   = {3'b000, tens_q} * 7'd10 + {3'b000, rx_msg[3:0]};
                        state_d = S_TERM; err_d = 1'b0;
                    end
                    S_TERM: if (rx_msg == 8'h0A) begin
                        push_req = 1'b1; err_d = 1'b0;
                    end
                    default: ;
                endcase
            end
        end else if (to_hit) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_3125) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            tens_q  <= '0;
            arg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tens_q  <= tens_d;
            arg_q   <= arg_d;
            err_q   <= err_d;
        end
    end

    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign pop  = cmd_rd && !cmd_empty;
    assign push = push_req && (!cmd_full || pop);

    always_ff @(posedge clk_3125) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            if (push_req && !push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_3125) begin
        if (push) mem_q[wr_ptr_q] <= {op_q, arg_q};
    end

    assign cmd_empty    = (cnt_q == '0);
    assign cmd_full     = (cnt_q == CW'(FIFO_DEPTH));
    assign cmd_op       = cmd_empty ? 2'd0 : mem_q[rd_ptr_q][8:7];
    assign cmd_arg      = cmd_empty ? 7'd0 : mem_q[rd_ptr_q][6:0];
    assign cmd_error    = err_q;
    assign cmd_overflow = ovf_q;

endmodule
